wb_arbiter: RTL



---
 rtl/wb_arbiter_if.sv | 38 +++
 rtl/wb_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Brief    : Writeback source handshake and register-file write port bundle.
// Revision : 1.0
// ============================================================================
interface wb_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int PREG_W  = 7,
    parameter int XLEN    = 32
);
    localparam int C_SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*PREG_W-1:0] src_rd;
    logic [NUM_SRC*XLEN-1:0]   src_data;
    logic                      wb_en;
    logic [XLEN-1:0]           wb_data;
    logic [PREG_W-1:0]         rd_index;
    logic [C_SRC_W-1:0]        wb_src;
    logic                      idle;

    // Arbiter view: accepts source beats and drives the register-file port.
    modport master (
        input  src_valid, src_rd, src_data,
        output src_ready, wb_en, wb_data, rd_index, wb_src, idle
    );

    // Environment view: functional units plus register file.
    modport slave (
        output src_valid, src_rd, src_data,
        input  src_ready, wb_en, wb_data, rd_index, wb_src, idle
    );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Per-source result FIFOs drained round-robin into one registered
//            register-file write port; physical register 0 is never written.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int PREG_W  = 7,
    parameter int XLEN    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    wb_arbiter_if.master  bus
);
    localparam int                   C_SRC_W    = $clog2(NUM_SRC);
    localparam int                   C_PTR_W    = $clog2(DEPTH);
    localparam int                   C_CNT_W    = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0]   C_FULL     = C_CNT_W'(DEPTH);
    localparam logic [C_SRC_W-1:0]   C_LAST_SRC = C_SRC_W'(NUM_SRC - 1);

    logic [PREG_W-1:0]  rd_mem_q   [NUM_SRC][DEPTH];
    logic [PREG_W-1:0]  rd_mem_d   [NUM_SRC][DEPTH];
    logic [XLEN-1:0]    data_mem_q [NUM_SRC][DEPTH];
    logic [XLEN-1:0]    data_mem_d [NUM_SRC][DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q   [NUM_SRC];
    logic [C_PTR_W-1:0] wr_ptr_d   [NUM_SRC];
    logic [C_PTR_W-1:0] rd_ptr_q   [NUM_SRC];
    logic [C_PTR_W-1:0] rd_ptr_d   [NUM_SRC];
    logic [C_CNT_W-1:0] count_q    [NUM_SRC];
    logic [C_CNT_W-1:0] count_d    [NUM_SRC];
    logic [C_SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic               wb_en_q, wb_en_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [PREG_W-1:0]  rd_index_q, rd_index_d;
    logic [C_SRC_W-1:0] wb_src_q, wb_src_d;

    logic [NUM_SRC-1:0] w_nonempty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_grant_vld;
    logic [C_SRC_W-1:0] w_grant_idx;
    logic [PREG_W-1:0]  w_head_rd;
    logic [XLEN-1:0]    w_head_data;

    // Ready depends only on registered occupancy, never on same-cycle dequeue.
    always_comb begin
        w_nonempty    = '0;
        w_push        = '0;
        bus.src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_nonempty[i]    = (count_q[i] != '0);
            bus.src_ready[i] = (count_q[i] != C_FULL);
            w_push[i]        = bus.src_valid[i] && (count_q[i] != C_FULL);
        end
    end

    always_comb begin : arb
        int                 cand;
        logic [C_SRC_W-1:0] cand_idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_SRC;
            cand_idx = C_SRC_W'(cand);
            if (!w_grant_vld && w_nonempty[cand_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = cand_idx;
            end
        end
    end

    assign w_head_rd   = rd_mem_q[w_grant_idx][rd_ptr_q[w_grant_idx]];
    assign w_head_data = data_mem_q[w_grant_idx][rd_ptr_q[w_grant_idx]];

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        wb_en_d    = 1'b0;
        wb_data_d  = wb_data_q;
        rd_index_d = rd_index_q;
        wb_src_d   = wb_src_q;
        w_pop      = '0;
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            rr_ptr_d = C_LAST_SRC;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                w_pop[i] = w_grant_vld && (w_grant_idx == C_SRC_W'(i));
                if (w_push[i]) begin
                    rd_mem_d[i][wr_ptr_q[i]]   = bus.src_rd[i*PREG_W +: PREG_W];
                    data_mem_d[i][wr_ptr_q[i]] = bus.src_data[i*XLEN +: XLEN];
                    wr_ptr_d[i]                = wr_ptr_q[i] + C_PTR_W'(1);
                end
                if (w_pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + C_PTR_W'(1);
                end
                count_d[i] = count_q[i] + C_CNT_W'(w_push[i]) - C_CNT_W'(w_pop[i]);
            end
            // A register-0 entry still consumes its slot and moves the pointer.
            if (w_grant_vld) begin
                rr_ptr_d   = w_grant_idx;
                wb_en_d    = (w_head_rd != '0);
                wb_data_d  = w_head_data;
                rd_index_d = w_head_rd;
                wb_src_d   = w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    rd_mem_q[i][j]   <= '0;
                    data_mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q   <= C_LAST_SRC;
            wb_en_q    <= 1'b0;
            wb_data_q  <= '0;
            rd_index_q <= '0;
            wb_src_q   <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_en_q    <= wb_en_d;
            wb_data_q  <= wb_data_d;
            rd_index_q <= rd_index_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign bus.wb_en    = wb_en_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.rd_index = rd_index_q;
    assign bus.wb_src   = wb_src_q;
    assign bus.idle     = (w_nonempty == '0) && !wb_en_q;

endmodule

`default_nettype wire
